// File: rtl/alu_pkg.sv
// Shared opcode, FSM and sizing definitions for the EX-stage ALU with its
// iterative multiply/divide unit.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] OP_ADDU  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] OP_SUBU  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] OP_OR    = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] OP_LUI   = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] OP_AND   = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] OP_XOR   = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] OP_SLT   = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] OP_SLTU  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] OP_ADD   = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] OP_SUB   = 4'b1001;
    localparam logic [ALU_CTRL_W-1:0] OP_MULT  = 4'b1010;
    localparam logic [ALU_CTRL_W-1:0] OP_MULTU = 4'b1011;
    localparam logic [ALU_CTRL_W-1:0] OP_DIV   = 4'b1100;
    localparam logic [ALU_CTRL_W-1:0] OP_DIVU  = 4'b1101;
    localparam logic [ALU_CTRL_W-1:0] OP_MTHI  = 4'b1110;
    localparam logic [ALU_CTRL_W-1:0] OP_MTLO  = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFix  = 2'b10
    } md_state_e;

    function automatic int unsigned lui_shift(input int unsigned width);
        return width / 2;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up and the architectural HI/LO registers.
module md_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_CTRL_W-1:0] op,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      hi,
    output logic [WIDTH-1:0]      lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_e          state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;       // product high half / partial remainder
    logic [WIDTH-1:0]   qreg;      // multiplier / dividend-then-quotient
    logic [WIDTH-1:0]   opnd;      // multiplicand / divisor magnitude
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               is_signed;
    logic               is_md_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        is_md_op  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        add_sum  = {1'b0, acc} + (qreg[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted  = {acc, qreg[WIDTH-1]};
        diff     = shifted - {1'b0, opnd};
        prod     = {acc, qreg};
        prod_fix = neg_q ? -prod : prod;
        // Divide by zero yields an all-ones quotient and the original dividend as remainder.
        quo_fix  = div_zero ? {WIDTH{1'b1}} : (neg_q ? -qreg : qreg);
        rem_fix  = neg_r ? -acc : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            acc      <= '0;
            qreg     <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && is_md_op) begin
                        acc      <= '0;
                        qreg     <= a_mag;
                        opnd     <= b_mag;
                        is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                        neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= is_signed && a[WIDTH-1];
                        div_zero <= (b == '0);
                        cnt      <= CNT_W'(WIDTH - 1);
                        busy     <= 1'b1;
                        state    <= StRun;
                    end else if (start && op == OP_MTHI) begin
                        hi   <= a;
                        done <= 1'b1;
                    end else if (start && op == OP_MTLO) begin
                        lo   <= a;
                        done <= 1'b1;
                    end
                end
                StRun: begin
                    if (is_div) begin
                        if (!diff[WIDTH]) begin
                            acc  <= diff[WIDTH-1:0];
                            qreg <= {qreg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc  <= shifted[WIDTH-1:0];
                            qreg <= {qreg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc  <= add_sum[WIDTH:1];
                        qreg <= {add_sum[0], qreg[WIDTH-1:1]};
                    end
                    if (cnt == '0) begin
                        state <= StFix;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StFix: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: single-cycle arithmetic/logic ops beside the iterative
// multiply/divide unit; HI/LO reads come out on C for the md opcodes.
module alu_md
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ALUctr,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              start,
    output logic [WIDTH-1:0]  C,
    output logic              Zero,
    output logic              Overflow,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  HI,
    output logic [WIDTH-1:0]  LO
);

    localparam int unsigned HALF = lui_shift(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic             lt_s;
    logic             lt_u;

    md_unit #(
        .WIDTH (WIDTH)
    ) u_md (
        .clk   (clk),
        .rst   (rst),
        .op    (ALUctr[ALU_CTRL_W-1:0]),
        .start (start),
        .a     (A),
        .b     (B),
        .busy  (busy),
        .done  (done),
        .hi    (HI),
        .lo    (LO)
    );

    always_comb begin
        sum  = A + B;
        dif  = A - B;
        lt_s = $signed(A) < $signed(B);
        lt_u = A < B;
    end

    always_comb begin
        C        = '0;
        Overflow = 1'b0;
        unique case (ALUctr[ALU_CTRL_W-1:0])
            OP_ADDU: C = sum;
            OP_SUBU: C = dif;
            OP_OR:   C = A | B;
            OP_LUI:  C = {B[HALF-1:0], {(WIDTH-HALF){1'b0}}};
            OP_AND:  C = A & B;
            OP_XOR:  C = A ^ B;
            OP_SLT:  C = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: C = {{(WIDTH-1){1'b0}}, lt_u};
            OP_ADD: begin
                C        = sum;
                Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                C        = dif;
                Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MTHI: C = HI;
            default: C = LO;
        endcase
        Zero = (C == '0);
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32.
module tb_alu_md;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ctr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         start;
    logic [W-1:0] c;
    logic         zero;
    logic         ovf;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;
    int n;
    logic saw_done;

    alu_md #(
        .WIDTH  (W),
        .CTRL_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ALUctr   (ctr),
        .A        (a),
        .B        (b),
        .start    (start),
        .C        (c),
        .Zero     (zero),
        .Overflow (ovf),
        .busy     (busy),
        .done     (done),
        .HI       (hi),
        .LO       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic comb_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        ctr   = op;
        a     = x;
        b     = y;
        start = 1'b0;
        #1;
    endtask

    // Launch one md op and wait for completion, checking latency and the done pulse.
    task automatic run_md(input string tag, input logic [3:0] op,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        int cyc;
        @(negedge clk);
        ctr   = op;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 64'(cyc), 64'd33);
        check({tag, " done"}, {63'b0, done}, 64'd1);
        @(negedge clk);
        check({tag, " done pulse width"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        ctr   = '0;
        a     = '0;
        b     = '0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset HI", 64'(hi), 64'h0);
        check("reset LO", 64'(lo), 64'h0);
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset done", {63'b0, done}, 64'd0);

        comb_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        check("ADD C", 64'(c), 64'h8000_0000);
        check("ADD ovf", {63'b0, ovf}, 64'd1);
        check("ADD zero", {63'b0, zero}, 64'd0);
        comb_op(OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001);
        check("ADDU ovf", {63'b0, ovf}, 64'd0);
        comb_op(OP_SUB, 32'h8000_0000, 32'h0000_0001);
        check("SUB C", 64'(c), 64'h7FFF_FFFF);
        check("SUB ovf", {63'b0, ovf}, 64'd1);
        comb_op(OP_LUI, 32'h0, 32'h0000_1234);
        check("LUI C", 64'(c), 64'h1234_0000);
        comb_op(OP_SUBU, 32'd5, 32'd5);
        check("SUBU C", 64'(c), 64'h0);
        check("SUBU zero", {63'b0, zero}, 64'd1);
        comb_op(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        check("SLT C", 64'(c), 64'd1);
        comb_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        check("SLTU C", 64'(c), 64'd0);
        comb_op(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("XOR C", 64'(c), 64'hFF00_EDCB);
        comb_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("AND C", 64'(c), 64'h00F0_1234);
        comb_op(OP_OR, 32'hF000_0001, 32'h0000_0010);
        check("OR C", 64'(c), 64'hF000_0011);

        run_md("MULT", OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("MULT HI", 64'(hi), 64'hFFFF_FFFF);
        check("MULT LO", 64'(lo), 64'hFFFF_FFEB);

        run_md("DIVU", OP_DIVU, 32'd100, 32'd7);
        check("DIVU LO", 64'(lo), 64'h0000_000E);
        check("DIVU HI", 64'(hi), 64'h0000_0002);

        run_md("MULTU", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("MULTU HI", 64'(hi), 64'hFFFF_FFFE);
        check("MULTU LO", 64'(lo), 64'h0000_0001);

        run_md("DIV minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("DIV minneg LO", 64'(lo), 64'h8000_0000);
        check("DIV minneg HI", 64'(hi), 64'h0);

        run_md("DIV", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("DIV LO", 64'(lo), 64'hFFFF_FFFD);
        check("DIV HI", 64'(hi), 64'hFFFF_FFFF);

        // Divide by zero with an MTHI start arriving mid-run.
        @(negedge clk);
        ctr   = OP_DIV;
        a     = 32'd9;
        b     = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        while (busy && n < 100) begin
            if (n == 5) begin
                ctr   = OP_MTHI;
                a     = 32'h0000_AAAA;
                b     = 32'd3;
                start = 1'b1;
                #1;
                check("HI read while busy", 64'(c), 64'hFFFF_FFFF);
            end else begin
                start = 1'b0;
            end
            if (n == 7) begin
                ctr = OP_ADDU;
                a   = 32'd2;
                b   = 32'd3;
                #1;
                check("ADDU while busy", 64'(c), 64'd5);
                check("HI untouched mid-run", 64'(hi), 64'hFFFF_FFFF);
            end
            n++;
            @(negedge clk);
        end
        check("DIV0 busy cycles", 64'(n), 64'd33);
        check("DIV0 done", {63'b0, done}, 64'd1);
        check("DIV0 HI", 64'(hi), 64'h0000_0009);
        check("DIV0 LO", 64'(lo), 64'hFFFF_FFFF);
        @(negedge clk);
        check("DIV0 no second done", {63'b0, done}, 64'd0);
        check("DIV0 HI after", 64'(hi), 64'h0000_0009);

        // Reset aborts a running MULTU.
        @(negedge clk);
        ctr   = OP_MULTU;
        a     = 32'h1234_5678;
        b     = 32'h0000_0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("MULTU busy before rst", {63'b0, busy}, 64'd1);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst busy", {63'b0, busy}, 64'd0);
        check("rst HI", 64'(hi), 64'h0);
        check("rst LO", 64'(lo), 64'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("no done after rst", {63'b0, saw_done}, 64'd0);

        // MTLO completes immediately without raising busy.
        ctr   = OP_MTLO;
        a     = 32'h0000_0055;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("MTLO LO", 64'(lo), 64'h0000_0055);
        check("MTLO done", {63'b0, done}, 64'd1);
        check("MTLO busy", {63'b0, busy}, 64'd0);
        check("MTLO HI kept", 64'(hi), 64'h0);
        @(negedge clk);
        check("MTLO done pulse width", {63'b0, done}, 64'd0);
        ctr = OP_MTLO;
        #1;
        check("MTLO read C", 64'(c), 64'h0000_0055);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
